ccdn_cccp_lut: RTL and testbench
================================

CCDN_CCCP_LUT -- requirements
Module: ccdn_cccp_lut

Interface
REQ-001 The block SHALL have the following parameters:
- NUM_QUEUES, default 8: output-queue one-hot width.
- LUT_DEPTH_BITS, default 4: table depth is 2^LUT_DEPTH_BITS entries.
- NAME_LENTH, default 32: content-name width.
- VN_LENTH, default 16: version-number width.

REQ-002 The block SHALL have one clock, clk, and the reset SHALL be named reset, synchronous and active-low.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low.
- lookup_req, in, 1: start a lookup.
- lookup_name, in, NAME_LENTH: name to match.
- lookup_vn, in, VN_LENTH: version number to check.
- lookup_done, out, 1: one-cycle result strobe.
- lookup_hit, out, 1: a valid entry's name matched.
- lookup_vn_match, out, 1: the hit entry's vn equals lookup_vn.
- lookup_oq, out, NUM_QUEUES: hit entry's oq.
- lookup_next_hop_ip, out, 32: hit entry's next hop.
- cccp_rd_addr, in, LUT_DEPTH_BITS: read address.
- cccp_rd_req, in, 1: read request.
- cccp_rd_name, out, NAME_LENTH: read-back name field.
- cccp_rd_vn, out, VN_LENTH: read-back vn field.
- cccp_rd_oq, out, NUM_QUEUES: read-back oq field.
- cccp_rd_next_hop_ip, out, 32: read-back next hop.
- cccp_rd_ack, out, 1: read-done pulse.
- cccp_wr_addr, in, LUT_DEPTH_BITS: write address.
- cccp_wr_req, in, 1: write request.
- cccp_wr_name, in, NAME_LENTH: name to write.
- cccp_wr_vn, in, VN_LENTH: vn to write.
- cccp_wr_oq, in, NUM_QUEUES: oq to write.
- cccp_wr_next_hop_ip, in, 32: next hop to write.
- cccp_wr_ack, out, 1: write-done pulse.

Function
REQ-004 Each table entry SHALL hold {name, vn, oq, next_hop_ip}, and an entry SHALL be valid iff its oq is non-zero.

REQ-005 A lookup SHALL match when the entry is valid and its name equals lookup_name; the vn field SHALL NOT take part in the match.

REQ-006 When several entries match, the lowest index SHALL win.

REQ-007 The lookup pipeline SHALL be fixed-latency, in two stages:
- Stage 1 registers the request and compares all entries in parallel.
- Stage 2 registers the priority-encoded result.
- lookup_done SHALL assert exactly 2 cycles after lookup_req and SHALL be high for one cycle.

REQ-008 The pipeline SHALL accept a new lookup_req every cycle with no stall, and each result SHALL correspond to its own request, in order.

REQ-009 On a miss, lookup_hit, lookup_vn_match, lookup_oq and lookup_next_hop_ip SHALL all be 0 during lookup_done.

REQ-010 The lookup outputs SHALL hold their values until the next lookup_done.

REQ-011 On a read, cccp_rd_ack SHALL pulse one cycle after cccp_rd_req, with all rd data fields valid in that same cycle and held until the next ack.

REQ-012 On a write, the entry SHALL be updated on the clock edge where cccp_wr_req is high, and cccp_wr_ack SHALL pulse on the next cycle.

REQ-013 Read/write requests are single-cycle pulses; a request held high SHALL be treated as one request per cycle.

REQ-014 For a read and a write in the same cycle to the same address, the read SHALL return the pre-write contents.

REQ-015 For a write and a lookup_req in the same cycle, the lookup SHALL see the pre-write table, and lookups requested from the next cycle onward SHALL see the new entry.

REQ-016 Writing oq = 0 SHALL invalidate the entry, which SHALL no longer hit.

REQ-017 Out-of-range addresses cannot occur, since the address width exactly spans the depth.

Reset
REQ-018 While reset is low at a clock edge, all table entries SHALL be cleared to 0 (all invalid).

REQ-019 While reset is low, all outputs SHALL be driven to 0, including lookup_done, cccp_rd_ack and cccp_wr_ack.

REQ-020 Lookups or accesses in flight when reset asserts SHALL be discarded, with no done or ack pulse after reset.

REQ-021 Requests presented while reset is low SHALL be ignored.

Structure
REQ-022 The entry-field widths and an entry-record layout SHALL live in the shared CCDN defines file alongside the other NetFPGA register defines.

REQ-023 A sub-module ccdn_prio_enc SHALL provide the 2^LUT_DEPTH_BITS-bit match vector to lowest-index one-hot/index encoding.

REQ-024 The table SHALL be register-based (flops) so that the parallel compare is possible.

Verification
REQ-025 A bench SHALL cover the following directed scenarios:
- Write entry 3 = {name 0xCAFE0001, vn 0x0005, oq 0x04, nh 0x0A000001}, then look up 0xCAFE0001/vn 5 -> done at +2, hit=1, vn_match=1, oq=0x04, nh=0x0A000001.
- Same entry, look up with vn 6 -> hit=1, vn_match=0, oq=0x04.
- Entries 2 and 7 both hold name 0x11, with oq 0x01 and 0x10 -> lookup returns oq=0x01; writing entry 2 oq=0 then looking up again -> oq=0x10.
- Back-to-back lookups (hit, miss, hit) on consecutive cycles -> three consecutive done pulses with the matching results; the miss has all-zero fields.
- Write entry 5 and look up its name in the same cycle -> miss; repeat the lookup next cycle -> hit.
- Same-cycle read/write to entry 1 -> rd_ack carries the old data; a later read returns the new data.
- Reset pulled low 1 cycle after lookup_req -> no lookup_done; all entries read back 0.

Source files
------------

// File: rtl/ccdn_cccp_lut_pkg.sv
// Shared CCDN defines for the content-name lookup table: default field widths
// and the layout of one table entry.
package ccdn_cccp_lut_pkg;

  localparam int CCDN_NUM_QUEUES     = 8;
  localparam int CCDN_LUT_DEPTH_BITS = 4;
  localparam int CCDN_NAME_LENTH     = 32;
  localparam int CCDN_VN_LENTH       = 16;
  localparam int CCDN_NEXT_HOP_W     = 32;

  // One entry at default widths; valid iff oq is non-zero.
  typedef struct packed {
    logic [CCDN_NAME_LENTH-1:0] name;
    logic [CCDN_VN_LENTH-1:0]   vn;
    logic [CCDN_NUM_QUEUES-1:0] oq;
    logic [CCDN_NEXT_HOP_W-1:0] next_hop_ip;
  } ccdn_entry_t;

endpackage

// File: rtl/ccdn_prio_enc.sv
// Lowest-index-wins priority encoder: match vector to one-hot and binary index.
module ccdn_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] i_vec,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx
);

  // Walking downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = W'(i);
      end
    end
  end

  assign o_onehot = i_vec & (~i_vec + N'(1));

endmodule

// File: rtl/ccdn_cccp_lut.sv
// CCDN content-name lookup table: flop-based table with a two-stage parallel
// lookup pipeline and single-cycle CCCP read/write access.
module ccdn_cccp_lut
  import ccdn_cccp_lut_pkg::*;
#(
  parameter int NUM_QUEUES     = CCDN_NUM_QUEUES,
  parameter int LUT_DEPTH_BITS = CCDN_LUT_DEPTH_BITS,
  parameter int NAME_LENTH     = CCDN_NAME_LENTH,
  parameter int VN_LENTH       = CCDN_VN_LENTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lookup_req,
  input  logic [NAME_LENTH-1:0]     lookup_name,
  input  logic [VN_LENTH-1:0]       lookup_vn,
  output logic                      lookup_done,
  output logic                      lookup_hit,
  output logic                      lookup_vn_match,
  output logic [NUM_QUEUES-1:0]     lookup_oq,
  output logic [CCDN_NEXT_HOP_W-1:0] lookup_next_hop_ip,
  input  logic [LUT_DEPTH_BITS-1:0] cccp_rd_addr,
  input  logic                      cccp_rd_req,
  output logic [NAME_LENTH-1:0]     cccp_rd_name,
  output logic [VN_LENTH-1:0]       cccp_rd_vn,
  output logic [NUM_QUEUES-1:0]     cccp_rd_oq,
  output logic [CCDN_NEXT_HOP_W-1:0] cccp_rd_next_hop_ip,
  output logic                      cccp_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] cccp_wr_addr,
  input  logic                      cccp_wr_req,
  input  logic [NAME_LENTH-1:0]     cccp_wr_name,
  input  logic [VN_LENTH-1:0]       cccp_wr_vn,
  input  logic [NUM_QUEUES-1:0]     cccp_wr_oq,
  input  logic [CCDN_NEXT_HOP_W-1:0] cccp_wr_next_hop_ip,
  output logic                      cccp_wr_ack
);

  localparam int DEPTH = 1 << LUT_DEPTH_BITS;

  logic [NAME_LENTH-1:0]      r_name [DEPTH];
  logic [VN_LENTH-1:0]        r_vn   [DEPTH];
  logic [NUM_QUEUES-1:0]      r_oq   [DEPTH];
  logic [CCDN_NEXT_HOP_W-1:0] r_nh   [DEPTH];

  logic [DEPTH-1:0]          w_match;
  logic [DEPTH-1:0]          w_onehot;
  logic [LUT_DEPTH_BITS-1:0] w_idx;
  logic                      w_hit;

  logic                       r_s1_valid;
  logic                       r_s1_hit;
  logic                       r_s1_vn_match;
  logic [NUM_QUEUES-1:0]      r_s1_oq;
  logic [CCDN_NEXT_HOP_W-1:0] r_s1_nh;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = (r_oq[i] != '0) && (r_name[i] == lookup_name);
    end
  end

  ccdn_prio_enc #(
    .N(DEPTH),
    .W(LUT_DEPTH_BITS)
  ) u_prio_enc (
    .i_vec   (w_match),
    .o_onehot(w_onehot),
    .o_idx   (w_idx)
  );

  assign w_hit = |w_onehot;

  // Stage 1 snapshots the winning entry at the request edge, so a write landing
  // on that same edge cannot leak into this lookup's result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_hit      <= 1'b0;
      r_s1_vn_match <= 1'b0;
      r_s1_oq       <= '0;
      r_s1_nh       <= '0;
    end else begin
      r_s1_valid <= lookup_req;
      if (lookup_req) begin
        r_s1_hit      <= w_hit;
        r_s1_vn_match <= w_hit && (r_vn[w_idx] == lookup_vn);
        r_s1_oq       <= w_hit ? r_oq[w_idx] : '0;
        r_s1_nh       <= w_hit ? r_nh[w_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lookup_done        <= 1'b0;
      lookup_hit         <= 1'b0;
      lookup_vn_match    <= 1'b0;
      lookup_oq          <= '0;
      lookup_next_hop_ip <= '0;
    end else begin
      lookup_done <= r_s1_valid;
      if (r_s1_valid) begin
        lookup_hit         <= r_s1_hit;
        lookup_vn_match    <= r_s1_vn_match;
        lookup_oq          <= r_s1_oq;
        lookup_next_hop_ip <= r_s1_nh;
      end
    end
  end

  // Reads sample the table before this edge's write takes effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_name[i] <= '0;
        r_vn[i]   <= '0;
        r_oq[i]   <= '0;
        r_nh[i]   <= '0;
      end
      cccp_rd_name        <= '0;
      cccp_rd_vn          <= '0;
      cccp_rd_oq          <= '0;
      cccp_rd_next_hop_ip <= '0;
      cccp_rd_ack         <= 1'b0;
      cccp_wr_ack         <= 1'b0;
    end else begin
      cccp_wr_ack <= cccp_wr_req;
      cccp_rd_ack <= cccp_rd_req;
      if (cccp_wr_req) begin
        r_name[cccp_wr_addr] <= cccp_wr_name;
        r_vn[cccp_wr_addr]   <= cccp_wr_vn;
        r_oq[cccp_wr_addr]   <= cccp_wr_oq;
        r_nh[cccp_wr_addr]   <= cccp_wr_next_hop_ip;
      end
      if (cccp_rd_req) begin
        cccp_rd_name        <= r_name[cccp_rd_addr];
        cccp_rd_vn          <= r_vn[cccp_rd_addr];
        cccp_rd_oq          <= r_oq[cccp_rd_addr];
        cccp_rd_next_hop_ip <= r_nh[cccp_rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_ccdn_cccp_lut.sv
// Directed bench for ccdn_cccp_lut with hand-computed expected values.
module tb_ccdn_cccp_lut;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_name = '0;
  logic [15:0] lookup_vn = '0;
  logic        lookup_done, lookup_hit, lookup_vn_match;
  logic [7:0]  lookup_oq;
  logic [31:0] lookup_next_hop_ip;
  logic [3:0]  cccp_rd_addr = '0;
  logic        cccp_rd_req = 1'b0;
  logic [31:0] cccp_rd_name;
  logic [15:0] cccp_rd_vn;
  logic [7:0]  cccp_rd_oq;
  logic [31:0] cccp_rd_next_hop_ip;
  logic        cccp_rd_ack;
  logic [3:0]  cccp_wr_addr = '0;
  logic        cccp_wr_req = 1'b0;
  logic [31:0] cccp_wr_name = '0;
  logic [15:0] cccp_wr_vn = '0;
  logic [7:0]  cccp_wr_oq = '0;
  logic [31:0] cccp_wr_next_hop_ip = '0;
  logic        cccp_wr_ack;

  int checks = 0;
  int errors = 0;

  ccdn_cccp_lut dut (
    .clk(clk), .reset(reset),
    .lookup_req(lookup_req), .lookup_name(lookup_name), .lookup_vn(lookup_vn),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit),
    .lookup_vn_match(lookup_vn_match), .lookup_oq(lookup_oq),
    .lookup_next_hop_ip(lookup_next_hop_ip),
    .cccp_rd_addr(cccp_rd_addr), .cccp_rd_req(cccp_rd_req),
    .cccp_rd_name(cccp_rd_name), .cccp_rd_vn(cccp_rd_vn),
    .cccp_rd_oq(cccp_rd_oq), .cccp_rd_next_hop_ip(cccp_rd_next_hop_ip),
    .cccp_rd_ack(cccp_rd_ack),
    .cccp_wr_addr(cccp_wr_addr), .cccp_wr_req(cccp_wr_req),
    .cccp_wr_name(cccp_wr_name), .cccp_wr_vn(cccp_wr_vn),
    .cccp_wr_oq(cccp_wr_oq), .cccp_wr_next_hop_ip(cccp_wr_next_hop_ip),
    .cccp_wr_ack(cccp_wr_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] name,
                               input logic [15:0] vn, input logic [7:0] oq,
                               input logic [31:0] nh);
    cccp_wr_addr = addr; cccp_wr_name = name; cccp_wr_vn = vn;
    cccp_wr_oq = oq; cccp_wr_next_hop_ip = nh; cccp_wr_req = 1'b1;
    tick();
    cccp_wr_req = 1'b0;
    checkOutput("wr_ack", 128'(cccp_wr_ack), 128'd1);
    tick();
  endtask

  task automatic checkResult(input string tag, input logic hit, input logic vnm,
                             input logic [7:0] oq, input logic [31:0] nh);
    checkOutput({tag, ".done"}, 128'(lookup_done), 128'd1);
    checkOutput({tag, ".res"},
                128'({lookup_hit, lookup_vn_match, lookup_oq, lookup_next_hop_ip}),
                128'({hit, vnm, oq, nh}));
  endtask

  task automatic doLookup(input string tag, input logic [31:0] name,
                          input logic [15:0] vn, input logic hit, input logic vnm,
                          input logic [7:0] oq, input logic [31:0] nh);
    lookup_name = name; lookup_vn = vn; lookup_req = 1'b1;
    tick();
    lookup_req = 1'b0;
    checkOutput({tag, ".early"}, 128'(lookup_done), 128'd0);
    tick();
    checkResult(tag, hit, vnm, oq, nh);
    tick();
    checkOutput({tag, ".pulse"}, 128'(lookup_done), 128'd0);
  endtask

  task automatic doRead(input string tag, input logic [3:0] addr,
                        input logic [87:0] exp);
    cccp_rd_addr = addr; cccp_rd_req = 1'b1;
    tick();
    cccp_rd_req = 1'b0;
    checkOutput({tag, ".ack"}, 128'(cccp_rd_ack), 128'd1);
    checkOutput({tag, ".data"},
                128'({cccp_rd_name, cccp_rd_vn, cccp_rd_oq, cccp_rd_next_hop_ip}),
                128'(exp));
  endtask

  initial begin
    int donesSeen;

    repeat (3) tick();
    checkOutput("rst.outs",
                128'({lookup_done, lookup_hit, lookup_vn_match, lookup_oq,
                      lookup_next_hop_ip, cccp_rd_ack, cccp_wr_ack}), 128'd0);
    checkOutput("rst.rd", 128'({cccp_rd_name, cccp_rd_vn, cccp_rd_oq,
                                cccp_rd_next_hop_ip}), 128'd0);
    reset = 1'b1;
    tick();

    applyStimulus(4'd3, 32'hCAFE0001, 16'h0005, 8'h04, 32'h0A000001);
    doLookup("lk_vn5", 32'hCAFE0001, 16'd5, 1'b1, 1'b1, 8'h04, 32'h0A000001);
    doLookup("lk_vn6", 32'hCAFE0001, 16'd6, 1'b1, 1'b0, 8'h04, 32'h0A000001);

    applyStimulus(4'd2, 32'h11, 16'h0001, 8'h01, 32'h02020202);
    applyStimulus(4'd7, 32'h11, 16'h0007, 8'h10, 32'h07070707);
    doLookup("prio", 32'h11, 16'd7, 1'b1, 1'b0, 8'h01, 32'h02020202);
    applyStimulus(4'd2, 32'h11, 16'h0001, 8'h00, 32'h02020202);
    doLookup("inval", 32'h11, 16'd7, 1'b1, 1'b1, 8'h10, 32'h07070707);

    lookup_name = 32'hCAFE0001; lookup_vn = 16'd5; lookup_req = 1'b1;
    tick();
    lookup_name = 32'hDEAD0000; lookup_vn = 16'd0;
    tick();
    checkResult("b2b.a", 1'b1, 1'b1, 8'h04, 32'h0A000001);
    lookup_name = 32'h11; lookup_vn = 16'd7;
    tick();
    checkResult("b2b.b", 1'b0, 1'b0, 8'h00, 32'h0);
    lookup_req = 1'b0;
    tick();
    checkResult("b2b.c", 1'b1, 1'b1, 8'h10, 32'h07070707);
    tick();
    checkOutput("b2b.end", 128'(lookup_done), 128'd0);

    cccp_wr_addr = 4'd5; cccp_wr_name = 32'h55555555; cccp_wr_vn = 16'd9;
    cccp_wr_oq = 8'h20; cccp_wr_next_hop_ip = 32'h05050505; cccp_wr_req = 1'b1;
    lookup_name = 32'h55555555; lookup_vn = 16'd9; lookup_req = 1'b1;
    tick();
    cccp_wr_req = 1'b0;
    checkOutput("same.wr_ack", 128'(cccp_wr_ack), 128'd1);
    tick();
    lookup_req = 1'b0;
    checkResult("same.miss", 1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    checkResult("same.hit", 1'b1, 1'b1, 8'h20, 32'h05050505);
    tick();
    checkOutput("same.hold", 128'({lookup_done, lookup_oq}), 128'({1'b0, 8'h20}));

    applyStimulus(4'd1, 32'h1111AAAA, 16'h0101, 8'h02, 32'h01010101);
    cccp_rd_addr = 4'd1; cccp_rd_req = 1'b1;
    cccp_wr_addr = 4'd1; cccp_wr_name = 32'h2222BBBB; cccp_wr_vn = 16'h0202;
    cccp_wr_oq = 8'h08; cccp_wr_next_hop_ip = 32'h02020202; cccp_wr_req = 1'b1;
    tick();
    cccp_rd_req = 1'b0; cccp_wr_req = 1'b0;
    checkOutput("rw.acks", 128'({cccp_rd_ack, cccp_wr_ack}), 128'd3);
    checkOutput("rw.old", 128'({cccp_rd_name, cccp_rd_vn, cccp_rd_oq,
                                cccp_rd_next_hop_ip}),
                128'({32'h1111AAAA, 16'h0101, 8'h02, 32'h01010101}));
    tick();
    doRead("rw.new", 4'd1, {32'h2222BBBB, 16'h0202, 8'h08, 32'h02020202});
    tick();
    checkOutput("rw.hold", 128'({cccp_rd_ack, cccp_rd_name}),
                128'({1'b0, 32'h2222BBBB}));

    lookup_name = 32'hCAFE0001; lookup_vn = 16'd5; lookup_req = 1'b1;
    tick();
    lookup_req = 1'b0; reset = 1'b0;
    tick();
    checkOutput("rst.flight", 128'({lookup_done, lookup_hit, lookup_oq}), 128'd0);
    tick();
    reset = 1'b1;
    donesSeen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (lookup_done) donesSeen++;
    end
    checkOutput("rst.nodone", 128'(donesSeen), 128'd0);
    for (int a = 0; a < 16; a++) begin
      doRead("rst.entry", 4'(a), 88'd0);
    end
    doLookup("rst.miss", 32'hCAFE0001, 16'd5, 1'b0, 1'b0, 8'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
